// File: rtl/multicycle_control_unit_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, ALU codes,
// FSM states, instruction classes and IR field positions.
package multicycle_control_unit_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_LW   = 4'h4;
   localparam logic [3:0] OP_SW   = 4'h5;
   localparam logic [3:0] OP_BEQ  = 4'h6;
   localparam logic [3:0] OP_JMP  = 4'h7;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;

   localparam int OP_HI = 15;
   localparam int OP_LO = 12;
   localparam int F1_HI = 11;
   localparam int F1_LO = 8;
   localparam int F2_HI = 7;
   localparam int F2_LO = 4;
   localparam int F3_HI = 3;
   localparam int F3_LO = 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   typedef enum logic [2:0] {
      CLS_R,
      CLS_LW,
      CLS_SW,
      CLS_BEQ,
      CLS_JMP,
      CLS_HALT,
      CLS_ILL
   } instr_class_t;

   function automatic instr_class_t classify(input logic [3:0] op);
      instr_class_t cls;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR: cls = CLS_R;
         OP_LW:                         cls = CLS_LW;
         OP_SW:                         cls = CLS_SW;
         OP_BEQ:                        cls = CLS_BEQ;
         OP_JMP:                        cls = CLS_JMP;
         OP_HALT:                       cls = CLS_HALT;
         default:                       cls = CLS_ILL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/multicycle_control_unit_instr_field_decoder.sv
// Combinational IR decoder: instruction class, register-file address fields
// and the sign-extended 4-bit offset.
module instr_field_decoder
   import multicycle_control_unit_pkg::*;
#(
   parameter int PC_W = 16
) (
   input  logic [15:0]     ir,
   output instr_class_t    cls,
   output logic [3:0]      a_rd1,
   output logic [3:0]      a_rd2,
   output logic [3:0]      a_off,
   output logic [3:0]      a_swlw,
   output logic [3:0]      a_wr_bt,
   output logic [PC_W-1:0] offset
);

   logic [3:0] f1;
   logic [3:0] f2;
   logic [3:0] f3;

   assign f1     = ir[F1_HI:F1_LO];
   assign f2     = ir[F2_HI:F2_LO];
   assign f3     = ir[F3_HI:F3_LO];
   assign cls    = classify(ir[OP_HI:OP_LO]);
   assign offset = {{(PC_W-4){f3[3]}}, f3};

   // Route IR fields to the address ports used by each class; others stay 0.
   always_comb begin
      a_rd1   = 4'd0;
      a_rd2   = 4'd0;
      a_off   = 4'd0;
      a_swlw  = 4'd0;
      a_wr_bt = 4'd0;
      case (cls)
         CLS_R: begin
            a_wr_bt = f1;
            a_rd1   = f2;
            a_rd2   = f3;
         end
         CLS_LW, CLS_SW: begin
            a_swlw = f1;
            a_off  = f2;
         end
         CLS_BEQ: begin
            a_rd1 = f1;
            a_rd2 = f2;
         end
         default: begin
            a_rd1 = 4'd0;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the 16-bit core: owns PC and IR, fetches over
// the instruction-memory handshake and sequences ALU, data memory and writeback.
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
#(
   parameter int              PC_W   = 16,
   parameter logic [PC_W-1:0] PC_RST = {PC_W{1'b0}}
) (
   input  logic            clk,
   input  logic            rst,
   output logic [PC_W-1:0] imem_addr,
   output logic            imem_req,
   input  logic            imem_ack,
   input  logic [15:0]     imem_rdata,
   output logic            dmem_req,
   output logic            dmem_we,
   input  logic            dmem_ack,
   input  logic            alu_zero,
   output logic [2:0]      alu_op,
   output logic            alu_src,
   output logic [3:0]      rf_a_rd1,
   output logic [3:0]      rf_a_rd2,
   output logic [3:0]      rf_a_off,
   output logic [3:0]      rf_a_swlw,
   output logic [3:0]      rf_a_wr_bt,
   output logic            c_reg_dst_write,
   output logic            c_reg_write,
   output logic            c_mem_to_reg,
   output logic            halted,
   output logic            illegal
);

   localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   state_t          state;
   state_t          state_nxt;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc_nxt;
   logic [15:0]     ir;
   logic [15:0]     ir_nxt;
   instr_class_t    cls;
   logic [PC_W-1:0] offset;

   instr_field_decoder #(.PC_W(PC_W)) u_decoder (
      .ir      (ir),
      .cls     (cls),
      .a_rd1   (rf_a_rd1),
      .a_rd2   (rf_a_rd2),
      .a_off   (rf_a_off),
      .a_swlw  (rf_a_swlw),
      .a_wr_bt (rf_a_wr_bt),
      .offset  (offset)
   );

   assign imem_addr = pc;

   // State, PC and IR registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
         pc    <= PC_RST;
         ir    <= 16'h0000;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         ir    <= ir_nxt;
      end
   end

   // Next-state logic and Moore output decode; acks only matter in their own state.
   always_comb begin
      state_nxt       = state;
      pc_nxt          = pc;
      ir_nxt          = ir;
      imem_req        = 1'b0;
      dmem_req        = 1'b0;
      dmem_we         = 1'b0;
      alu_op          = ALU_ADD;
      alu_src         = 1'b0;
      c_reg_dst_write = 1'b0;
      c_reg_write     = 1'b0;
      c_mem_to_reg    = 1'b0;
      halted          = 1'b0;
      illegal         = 1'b0;
      case (state)
         S_IDLE: begin
            state_nxt = S_FETCH;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_nxt    = imem_rdata;
               pc_nxt    = pc + PC_ONE;
               state_nxt = S_DECODE;
            end else begin
               state_nxt = S_FETCH;
            end
         end
         S_DECODE: begin
            case (cls)
               CLS_JMP: begin
                  // Jump keeps the PC page above bit 11 (PC already incremented).
                  pc_nxt    = {pc[PC_W-1:12], ir[11:0]};
                  state_nxt = S_FETCH;
               end
               CLS_HALT: state_nxt = S_HALT;
               CLS_ILL: begin
                  illegal   = 1'b1;
                  state_nxt = S_FETCH;
               end
               default:  state_nxt = S_EXEC;
            endcase
         end
         S_EXEC: begin
            case (cls)
               CLS_R: begin
                  alu_op    = {1'b0, ir[OP_LO+1:OP_LO]};
                  state_nxt = S_WB;
               end
               CLS_LW, CLS_SW: begin
                  alu_op    = ALU_ADD;
                  alu_src   = 1'b1;
                  state_nxt = S_MEM;
               end
               CLS_BEQ: begin
                  alu_op = ALU_SUB;
                  if (alu_zero) begin
                     pc_nxt = pc + offset;
                  end else begin
                     pc_nxt = pc;
                  end
                  state_nxt = S_FETCH;
               end
               default: state_nxt = S_FETCH;
            endcase
         end
         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = (cls == CLS_SW);
            if (dmem_ack) begin
               state_nxt = (cls == CLS_LW) ? S_WB : S_FETCH;
            end else begin
               state_nxt = S_MEM;
            end
         end
         S_WB: begin
            c_reg_write     = 1'b1;
            c_reg_dst_write = (cls == CLS_R);
            c_mem_to_reg    = (cls == CLS_LW);
            state_nxt       = S_FETCH;
         end
         S_HALT: begin
            halted    = 1'b1;
            state_nxt = S_HALT;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit with hand-computed
// expectations for each instruction class, stalls, halt and reset.
module tb_multicycle_control_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] imem_addr;
   logic        imem_req;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_ack;
   logic        alu_zero;
   logic [2:0]  alu_op;
   logic        alu_src;
   logic [3:0]  rf_a_rd1;
   logic [3:0]  rf_a_rd2;
   logic [3:0]  rf_a_off;
   logic [3:0]  rf_a_swlw;
   logic [3:0]  rf_a_wr_bt;
   logic        c_reg_dst_write;
   logic        c_reg_write;
   logic        c_mem_to_reg;
   logic        halted;
   logic        illegal;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   multicycle_control_unit #(.PC_W(16), .PC_RST(16'h0000)) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_addr       (imem_addr),
      .imem_req        (imem_req),
      .imem_ack        (imem_ack),
      .imem_rdata      (imem_rdata),
      .dmem_req        (dmem_req),
      .dmem_we         (dmem_we),
      .dmem_ack        (dmem_ack),
      .alu_zero        (alu_zero),
      .alu_op          (alu_op),
      .alu_src         (alu_src),
      .rf_a_rd1        (rf_a_rd1),
      .rf_a_rd2        (rf_a_rd2),
      .rf_a_off        (rf_a_off),
      .rf_a_swlw       (rf_a_swlw),
      .rf_a_wr_bt      (rf_a_wr_bt),
      .c_reg_dst_write (c_reg_dst_write),
      .c_reg_write     (c_reg_write),
      .c_mem_to_reg    (c_mem_to_reg),
      .halted          (halted),
      .illegal         (illegal)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for a fetch request, then answers it with a zero-wait ack.
   task automatic do_fetch(input logic [15:0] instr);
      int n = 0;
      while (imem_req !== 1'b1 && n < 8) begin
         tick();
         n++;
      end
      checks++;
      if (imem_req !== 1'b1) begin
         errors++;
         $display("FAIL fetch_wait imem_req=%b required 1", imem_req);
      end
      imem_rdata = instr;
      imem_ack   = 1'b1;
      tick();
      imem_ack   = 1'b0;
      imem_rdata = 16'h0000;
   endtask

   task automatic test_reset();
      rst = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; alu_zero = 1'b0; imem_rdata = 16'h0000;
      tick();
      tick();
      checks++;
      if ({imem_req, dmem_req, halted, illegal, c_reg_write} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_flags got=%b required 00000", {imem_req, dmem_req, halted, illegal, c_reg_write});
      end
      checks++;
      if (imem_addr !== 16'h0000) begin
         errors++;
         $display("FAIL reset_pc got=%h required 0000", imem_addr);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
         errors++;
         $display("FAIL first_fetch req=%b addr=%h required 1/0000", imem_req, imem_addr);
      end
   endtask

   task automatic test_r_type();
      do_fetch(16'h0123);
      checks++;
      if ({rf_a_rd1, rf_a_rd2, rf_a_wr_bt} !== {4'd2, 4'd3, 4'd1}) begin
         errors++;
         $display("FAIL r_addr got=%h required 231", {rf_a_rd1, rf_a_rd2, rf_a_wr_bt});
      end
      checks++;
      if (imem_addr !== 16'h0001 || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL r_decode_pc addr=%h req=%b required 0001/0", imem_addr, imem_req);
      end
      tick();
      checks++;
      if (alu_op !== 3'd0 || alu_src !== 1'b0 || c_reg_write !== 1'b0) begin
         errors++;
         $display("FAIL r_exec op=%0d src=%b wr=%b required 0/0/0", alu_op, alu_src, c_reg_write);
      end
      tick();
      checks++;
      if ({c_reg_write, c_reg_dst_write, c_mem_to_reg} !== 3'b110) begin
         errors++;
         $display("FAIL r_wb got=%b required 110", {c_reg_write, c_reg_dst_write, c_mem_to_reg});
      end
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0001 || c_reg_write !== 1'b0) begin
         errors++;
         $display("FAIL r_next req=%b addr=%h wr=%b required 1/0001/0", imem_req, imem_addr, c_reg_write);
      end
   endtask

   task automatic test_lw_stall();
      do_fetch(16'h4452);
      checks++;
      if ({rf_a_swlw, rf_a_off} !== {4'd4, 4'd5}) begin
         errors++;
         $display("FAIL lw_addr got=%h required 45", {rf_a_swlw, rf_a_off});
      end
      tick();
      checks++;
      if (alu_src !== 1'b1 || alu_op !== 3'd0) begin
         errors++;
         $display("FAIL lw_exec src=%b op=%0d required 1/0", alu_src, alu_op);
      end
      tick();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (dmem_req !== 1'b1 || dmem_we !== 1'b0) begin
            errors++;
            $display("FAIL lw_stall%0d req=%b we=%b required 1/0", i, dmem_req, dmem_we);
         end
         tick();
      end
      checks++;
      if (dmem_req !== 1'b1) begin
         errors++;
         $display("FAIL lw_ack_cycle req=%b required 1", dmem_req);
      end
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
      checks++;
      if ({c_reg_write, c_mem_to_reg, c_reg_dst_write, dmem_req} !== 4'b1100) begin
         errors++;
         $display("FAIL lw_wb got=%b required 1100", {c_reg_write, c_mem_to_reg, c_reg_dst_write, dmem_req});
      end
      checks++;
      if ({rf_a_swlw, rf_a_off} !== {4'd4, 4'd5}) begin
         errors++;
         $display("FAIL lw_wb_addr got=%h required 45", {rf_a_swlw, rf_a_off});
      end
      tick();
   endtask

   task automatic test_sw();
      do_fetch(16'h5672);
      checks++;
      if ({rf_a_swlw, rf_a_off, c_reg_write} !== {4'd6, 4'd7, 1'b0}) begin
         errors++;
         $display("FAIL sw_decode got=%h required 0ce", {rf_a_swlw, rf_a_off, c_reg_write});
      end
      tick();
      checks++;
      if (alu_src !== 1'b1 || c_reg_write !== 1'b0) begin
         errors++;
         $display("FAIL sw_exec src=%b wr=%b required 1/0", alu_src, c_reg_write);
      end
      tick();
      checks++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || c_reg_write !== 1'b0) begin
         errors++;
         $display("FAIL sw_mem req=%b we=%b wr=%b required 1/1/0", dmem_req, dmem_we, c_reg_write);
      end
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0003 || c_reg_write !== 1'b0) begin
         errors++;
         $display("FAIL sw_next req=%b addr=%h wr=%b required 1/0003/0", imem_req, imem_addr, c_reg_write);
      end
   endtask

   task automatic test_illegal(input logic [15:0] exp_next);
      do_fetch(16'h9000);
      checks++;
      if (illegal !== 1'b1) begin
         errors++;
         $display("FAIL illegal_pulse got=%b required 1", illegal);
      end
      tick();
      checks++;
      if (illegal !== 1'b0 || imem_req !== 1'b1 || imem_addr !== exp_next) begin
         errors++;
         $display("FAIL illegal_next ill=%b req=%b addr=%h required 0/1/%h", illegal, imem_req, imem_addr, exp_next);
      end
   endtask

   task automatic test_beq(input logic zero, input logic [15:0] exp_next);
      do_fetch(16'h612E);
      checks++;
      if ({rf_a_rd1, rf_a_rd2} !== {4'd1, 4'd2} || imem_addr !== 16'h0005) begin
         errors++;
         $display("FAIL beq_decode rd=%h addr=%h required 12/0005", {rf_a_rd1, rf_a_rd2}, imem_addr);
      end
      alu_zero = zero;
      tick();
      checks++;
      if (alu_op !== 3'd1 || alu_src !== 1'b0) begin
         errors++;
         $display("FAIL beq_exec op=%0d src=%b required 1/0", alu_op, alu_src);
      end
      tick();
      alu_zero = 1'b0;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_next) begin
         errors++;
         $display("FAIL beq_target zero=%b addr=%h required %h", zero, imem_addr, exp_next);
      end
   endtask

   task automatic test_jmp();
      do_fetch(16'h7FFF);
      tick();
      checks++;
      if (imem_addr !== 16'h0FFF) begin
         errors++;
         $display("FAIL jmp_low addr=%h required 0fff", imem_addr);
      end
      test_illegal(16'h1000);
      do_fetch(16'h7ABC);
      checks++;
      if (imem_addr !== 16'h1001) begin
         errors++;
         $display("FAIL jmp_decode_pc addr=%h required 1001", imem_addr);
      end
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h1ABC) begin
         errors++;
         $display("FAIL jmp_target req=%b addr=%h required 1/1abc", imem_req, imem_addr);
      end
   endtask

   task automatic test_halt();
      do_fetch(16'hF000);
      tick();
      imem_ack = 1'b1;
      dmem_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({halted, imem_req, dmem_req} !== 3'b100) begin
            errors++;
            $display("FAIL halt%0d got=%b required 100", i, {halted, imem_req, dmem_req});
         end
         tick();
      end
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
   endtask

   task automatic test_reset_mid_mem();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      checks++;
      if ({halted, imem_req} !== 2'b00) begin
         errors++;
         $display("FAIL halt_reset got=%b required 00", {halted, imem_req});
      end
      tick();
      do_fetch(16'h4452);
      tick();
      tick();
      checks++;
      if (dmem_req !== 1'b1 || imem_addr !== 16'h0001) begin
         errors++;
         $display("FAIL mid_mem_pre req=%b addr=%h required 1/0001", dmem_req, imem_addr);
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({dmem_req, imem_req} !== 2'b00 || imem_addr !== 16'h0000 || rf_a_swlw !== 4'd0) begin
         errors++;
         $display("FAIL mid_mem_reset req=%b addr=%h swlw=%0d required 00/0000/0", {dmem_req, imem_req}, imem_addr, rf_a_swlw);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
         errors++;
         $display("FAIL post_reset_fetch req=%b addr=%h required 1/0000", imem_req, imem_addr);
      end
   endtask

   initial begin
      test_reset();
      test_r_type();
      test_lw_stall();
      test_sw();
      test_illegal(16'h0004);
      test_beq(1'b1, 16'h0003);
      test_illegal(16'h0004);
      test_beq(1'b0, 16'h0005);
      test_jmp();
      test_halt();
      test_reset_mid_mem();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
